// File: rtl/sel_mux_arbiter.sv
// N-channel registered arbitrating multiplexer with valid/ready flow control.
// Selection is fixed-priority or round-robin, with optional inversion of the chosen word.
module sel_mux_arbiter #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic           inv,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [CW-1:0]  out_ch,
    input  logic           out_ready
);

    logic [CW-1:0] last;
    logic [CW-1:0] gnt_fp;
    logic [CW-1:0] gnt_rr;
    logic [CW-1:0] gnt;
    logic          any_valid;
    logic          load_en;
    logic          grant_en;
    logic          fp_found;
    logic          rr_found;
    logic [W-1:0]  sel_data;
    int            rr_idx;

    assign any_valid = |in_valid;
    assign load_en   = !out_valid || out_ready;
    assign grant_en  = load_en && any_valid;

    always_comb begin
        gnt_fp   = '0;
        fp_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!fp_found && in_valid[k]) begin
                gnt_fp   = CW'(k);
                fp_found = 1'b1;
            end
        end
    end

    // Search starts one past the last grant and wraps modulo N.
    always_comb begin
        gnt_rr   = '0;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int i = 0; i < N; i++) begin
            rr_idx = (int'(last) + 1 + i) % N;
            if (!rr_found && in_valid[rr_idx]) begin
                gnt_rr   = CW'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end

    assign gnt      = (mode && N > 1) ? gnt_rr : gnt_fp;
    assign sel_data = in_data[int'(gnt)*W +: W];

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < N; k++) begin
            in_ready[k] = rst_n && grant_en && (gnt == CW'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            last      <= CW'(N - 1);
        end else if (load_en) begin
            if (any_valid) begin
                out_valid <= 1'b1;
                out_data  <= inv ? ~sel_data : sel_data;
                out_ch    <= gnt;
                last      <= gnt;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sel_mux_arbiter.sv
// Directed bench for sel_mux_arbiter: a 4x8 instance plus a single-channel instance.
module tb_sel_mux_arbiter;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic        inv;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;
    logic [7:0]  d [4];

    logic        in_valid1;
    logic [7:0]  in_data1;
    logic        in_ready1;
    logic        out_valid1;
    logic [7:0]  out_data1;
    logic        out_ch1;
    logic        out_ready1;

    int checks = 0;
    int errors = 0;

    assign in_data = {d[3], d[2], d[1], d[0]};

    sel_mux_arbiter #(.N(4), .W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .inv(inv),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    sel_mux_arbiter #(.N(1), .W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .inv(inv),
        .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ch(out_ch1),
        .out_ready(out_ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] dt, input logic [1:0] ch);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_data"},  32'(out_data),  32'(dt));
        check({tag, "_ch"},    32'(out_ch),    32'(ch));
    endtask

    logic [1:0] rr_seq [6];

    initial begin
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst_n = 1'b0; mode = 1'b0; inv = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) d[k] = 8'h10 + 8'(k);
        in_valid1 = 1'b0; in_data1 = 8'h00; out_ready1 = 1'b1;
        #2;
        check_out("reset", 1'b0, 8'h00, 2'd0);
        check("reset_in_ready", 32'(in_ready), 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // Round-robin with all channels valid
        mode = 1'b1; in_valid = 4'hF;
        #1;
        check("rr_first_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 6; i++) begin
            step();
            check_out("rr_seq", 1'b1, 8'h10 + 8'(rr_seq[i]), rr_seq[i]);
        end

        // Fixed priority, channel 0 idle
        mode = 1'b0; in_valid = 4'b1110;
        #1;
        check("fp_ready", 32'(in_ready), 32'b0010);
        step();
        check_out("fp_beat0", 1'b1, 8'h11, 2'd1);
        step();
        check_out("fp_beat1", 1'b1, 8'h11, 2'd1);
        check("fp_ready_hold", 32'(in_ready), 32'b0010);

        // Wrap: grant ch3 so last=3, then only ch1 valid in round-robin
        in_valid = 4'b1000;
        step();
        check_out("wrap_setup", 1'b1, 8'h13, 2'd3);
        mode = 1'b1; in_valid = 4'b0010;
        #1;
        check("wrap_ready", 32'(in_ready), 32'b0010);
        step();
        check_out("wrap_grant", 1'b1, 8'h11, 2'd1);

        // Inversion then backpressure with inv toggling
        mode = 1'b0; inv = 1'b1; d[2] = 8'hA5; in_valid = 4'b0100;
        step();
        check_out("inv_beat", 1'b1, 8'h5A, 2'd2);
        out_ready = 1'b0; in_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            inv = ~inv;
            #1;
            check("stall_ready", 32'(in_ready), 32'h0);
            step();
            check_out("stall", 1'b1, 8'h5A, 2'd2);
        end
        inv = 1'b0; out_ready = 1'b1;
        #1;
        check("release_ready", 32'(in_ready), 32'b0001);
        step();
        check_out("release_beat", 1'b1, 8'h10, 2'd0);

        // Idle: valid drops, payload holds
        in_valid = 4'b1000;
        step();
        check_out("pre_idle", 1'b1, 8'h13, 2'd3);
        in_valid = 4'b0000;
        #1;
        check("idle_ready", 32'(in_ready), 32'h0);
        step();
        check_out("idle", 1'b0, 8'h13, 2'd3);

        // Mid-stream asynchronous reset while stalled full
        in_valid = 4'b0100;
        step();
        check_out("pre_reset", 1'b1, 8'hA5, 2'd2);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 1'b0, 8'h00, 2'd0);
        check("async_reset_ready", 32'(in_ready), 32'h0);
        step();
        rst_n = 1'b1; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        #1;
        check("post_reset_ready", 32'(in_ready), 32'h1);
        step();
        check_out("post_reset_rr", 1'b1, 8'h10, 2'd0);
        in_valid = 4'h0;

        // Single-channel build
        in_valid1 = 1'b1; in_data1 = 8'h3C; inv = 1'b0; mode = 1'b1;
        #1;
        check("n1_ready", 32'(in_ready1), 32'h1);
        step();
        check("n1_valid", 32'(out_valid1), 32'h1);
        check("n1_data",  32'(out_data1),  32'h3C);
        check("n1_ch",    32'(out_ch1),    32'h0);
        in_data1 = 8'hC3; mode = 1'b0;
        step();
        check("n1_data2", 32'(out_data1), 32'hC3);
        check("n1_ch2",   32'(out_ch1),   32'h0);
        in_valid1 = 1'b0;
        step();
        check("n1_idle",  32'(out_valid1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
